// File: rtl/decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : decode_issue_ctrl
//  Description : Front-end decode sequencer. Pops the fetch FIFO when the
//                issue slot can take an instruction and no register hazard
//                exists. Keeps a per-register busy scoreboard that writeback
//                clears, and holds one decoded instruction under a
//                valid/ready handshake to the execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_issue_ctrl #(
   parameter int NREG    = 32,
   parameter int RIDX_W  = 5,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               fifo_empty,
   input  logic [INSTR_W-1:0] fifo_data_out,
   output logic               fifo_rd_en,
   input  logic [RIDX_W-1:0]  dec_rs1,
   input  logic [RIDX_W-1:0]  dec_rs2,
   input  logic [RIDX_W-1:0]  dec_rd,
   input  logic               dec_src1_is_reg,
   input  logic               dec_src2_is_reg,
   input  logic               dec_need_to_wb,
   output logic               issue_valid,
   input  logic               issue_ready,
   output logic [INSTR_W-1:0] issue_instr,
   output logic [RIDX_W-1:0]  issue_rd,
   output logic               issue_wb,
   input  logic               wb_valid,
   input  logic [RIDX_W-1:0]  wb_rd,
   input  logic               flush,
   output logic [NREG-1:0]    busy_vec,
   output logic [CNT_W-1:0]   stall_cycles
);

   // Issue slot states: the slot either holds nothing or one decoded instruction.
   localparam logic [0:0]       S_EMPTY   = 1'b0;
   localparam logic [0:0]       S_FULL    = 1'b1;
   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
   localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

   logic [0:0]         r_state;
   logic [INSTR_W-1:0] r_instr;
   logic [RIDX_W-1:0]  r_rd;
   logic               r_wb;
   logic [NREG-1:0]    r_busy;
   logic [CNT_W-1:0]   r_stall;

   logic               w_valid;
   logic               w_fire;
   logic               w_slot_free;
   logic [NREG-1:0]    w_eb;
   logic               w_hazard;
   logic               w_pop;
   logic               w_stall;

   assign w_valid     = (r_state == S_FULL);
   assign w_fire      = w_valid & issue_ready & ~flush;
   assign w_slot_free = ~w_valid | w_fire;

   // Effective busy view: writeback this cycle bypasses its clear, the issuing
   // producer sets its rd early, and x0 is never busy. This is also the
   // scoreboard's next value.
   always_comb begin
      w_eb = r_busy;
      if (wb_valid) begin
         w_eb[wb_rd] = 1'b0;
      end
      if (w_fire && r_wb && (r_rd != '0)) begin
         w_eb[r_rd] = 1'b1;
      end
      w_eb[0] = 1'b0;
   end

   // RAW on either source, WAW on the destination.
   assign w_hazard = (dec_src1_is_reg & w_eb[dec_rs1])
                   | (dec_src2_is_reg & w_eb[dec_rs2])
                   | (dec_need_to_wb  & w_eb[dec_rd]);

   assign w_pop      = ~fifo_empty & w_slot_free & ~w_hazard & ~flush & ~reset;
   assign w_stall    = ~fifo_empty & w_slot_free &  w_hazard & ~flush;
   assign fifo_rd_en = w_pop;

   // Issue slot: flush drops the held instruction, a pop refills it, a lone
   // fire empties it; otherwise contents stay put under backpressure.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_EMPTY;
         r_instr <= '0;
         r_rd    <= '0;
         r_wb    <= 1'b0;
      end else if (flush) begin
         r_state <= S_EMPTY;
      end else if (w_pop) begin
         r_state <= S_FULL;
         r_instr <= fifo_data_out;
         r_rd    <= dec_rd;
         r_wb    <= dec_need_to_wb;
      end else if (w_fire) begin
         r_state <= S_EMPTY;
      end
   end

   // Scoreboard: writeback clear then issue set, so a same-index set wins.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_eb;
      end
   end

   // Saturating count of cycles lost to register hazards only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stall <= '0;
      end else if (w_stall && (r_stall != C_CNT_MAX)) begin
         r_stall <= r_stall + C_CNT_ONE;
      end
   end

   assign issue_valid  = w_valid;
   assign issue_instr  = r_instr;
   assign issue_rd     = r_rd;
   assign issue_wb     = r_wb;
   assign busy_vec     = r_busy;
   assign stall_cycles = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_issue_ctrl
//  Description : Self-checking bench for decode_issue_ctrl: hazard vector
//                table plus hand-written streaming, RAW, backpressure, flush,
//                x0/collision, saturation and reset sequences, with a
//                scoreboard of popped instructions checked at issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_issue_ctrl;

   localparam int NREG = 32;
   localparam int RW   = 5;
   localparam int IW   = 32;
   localparam int CW   = 4;

   typedef struct {
      logic [IW-1:0] instr;
      logic [RW-1:0] rs1, rs2, rd;
      bit            s1, s2, wb;
   } ins_t;

   typedef struct {
      logic [IW-1:0] instr;
      logic [RW-1:0] rd;
      bit            wb;
   } sb_t;

   typedef struct {
      ins_t ins;
      bit   exp_rd_en;
   } vec_t;

   logic            clock, reset;
   logic            fifo_empty;
   logic [IW-1:0]   fifo_data_out;
   logic            fifo_rd_en;
   logic [RW-1:0]   dec_rs1, dec_rs2, dec_rd;
   logic            dec_src1_is_reg, dec_src2_is_reg, dec_need_to_wb;
   logic            issue_valid, issue_ready;
   logic [IW-1:0]   issue_instr;
   logic [RW-1:0]   issue_rd;
   logic            issue_wb;
   logic            wb_valid;
   logic [RW-1:0]   wb_rd;
   logic            flush;
   logic [NREG-1:0] busy_vec;
   logic [CW-1:0]   stall_cycles;

   int   n_cmp = 0;
   int   n_fail = 0;
   ins_t fq[$];
   sb_t  sbq[$];
   vec_t tv[8];
   int   exp_stall;

   decode_issue_ctrl #(.NREG(NREG), .RIDX_W(RW), .INSTR_W(IW), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset),
      .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
      .dec_src1_is_reg(dec_src1_is_reg), .dec_src2_is_reg(dec_src2_is_reg),
      .dec_need_to_wb(dec_need_to_wb),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
      .issue_rd(issue_rd), .issue_wb(issue_wb),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
      .busy_vec(busy_vec), .stall_cycles(stall_cycles)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic ins_t mk(input logic [IW-1:0] i, input logic [RW-1:0] a,
                               input logic [RW-1:0] b, input logic [RW-1:0] d,
                               input bit s1, input bit s2, input bit w);
      ins_t r;
      r.instr = i; r.rs1 = a; r.rs2 = b; r.rd = d; r.s1 = s1; r.s2 = s2; r.wb = w;
      return r;
   endfunction

   task automatic apply_head();
      if (fq.size() == 0) begin
         fifo_empty = 1'b1; fifo_data_out = '0;
         dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
         dec_src1_is_reg = 1'b0; dec_src2_is_reg = 1'b0; dec_need_to_wb = 1'b0;
      end else begin
         fifo_empty = 1'b0; fifo_data_out = fq[0].instr;
         dec_rs1 = fq[0].rs1; dec_rs2 = fq[0].rs2; dec_rd = fq[0].rd;
         dec_src1_is_reg = fq[0].s1; dec_src2_is_reg = fq[0].s2; dec_need_to_wb = fq[0].wb;
      end
   endtask

   task automatic at_neg();
      @(negedge clock);
   endtask

   task automatic adv();
      bit p;
      p = fifo_rd_en;
      @(posedge clock);
      #1;
      if (p && fq.size() > 0) void'(fq.pop_front());
      apply_head();
   endtask

   task automatic cycle();
      at_neg();
      adv();
   endtask

   // Scoreboard: record each pop, compare at each fire, drop the held one on flush.
   always @(negedge clock) begin
      sb_t e;
      if (!reset) begin
         if (issue_valid && issue_ready && !flush) begin
            if (sbq.size() == 0) begin
               chk("sb_unexpected_issue", 64'(issue_instr), 64'hDEAD);
            end else begin
               e = sbq.pop_front();
               chk("sb_instr", 64'(issue_instr), 64'(e.instr));
               chk("sb_rd", 64'(issue_rd), 64'(e.rd));
               chk("sb_wb", 64'(issue_wb), 64'(e.wb));
            end
         end else if (issue_valid && flush && sbq.size() > 0) begin
            void'(sbq.pop_front());
         end
         if (fifo_rd_en) begin
            e.instr = fifo_data_out; e.rd = dec_rd; e.wb = dec_need_to_wb;
            sbq.push_back(e);
         end
      end
   end

   initial begin
      // Hazard table, applied with x1..x4 busy.
      tv[0].ins = mk(32'h1000,  1,  0, 20, 1, 0, 0); tv[0].exp_rd_en = 1'b0;
      tv[1].ins = mk(32'h1001,  1,  5, 20, 0, 1, 0); tv[1].exp_rd_en = 1'b1;
      tv[2].ins = mk(32'h1002,  0,  3, 21, 0, 1, 0); tv[2].exp_rd_en = 1'b0;
      tv[3].ins = mk(32'h1003,  0,  0,  4, 0, 0, 1); tv[3].exp_rd_en = 1'b0;
      tv[4].ins = mk(32'h1004,  9,  0,  4, 1, 0, 0); tv[4].exp_rd_en = 1'b1;
      tv[5].ins = mk(32'h1005,  0,  0,  0, 1, 1, 1); tv[5].exp_rd_en = 1'b1;
      tv[6].ins = mk(32'h1006,  2,  0, 22, 1, 0, 0); tv[6].exp_rd_en = 1'b0;
      tv[7].ins = mk(32'h1007, 31, 30, 29, 1, 1, 0); tv[7].exp_rd_en = 1'b1;

      // Reset state, with a non-empty FIFO to show no pop under reset.
      reset = 1'b1; issue_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
      fq.push_back(mk(32'hAAAA, 0, 0, 1, 0, 0, 1));
      apply_head();
      @(posedge clock); #1;
      chk("rst_rd_en", 64'(fifo_rd_en), 0);
      chk("rst_valid", 64'(issue_valid), 0);
      chk("rst_instr", 64'(issue_instr), 0);
      chk("rst_busy", 64'(busy_vec), 0);
      chk("rst_stall", 64'(stall_cycles), 0);
      fq.delete(); apply_head();
      @(posedge clock); #1;
      reset = 1'b0;

      // Streaming: four independent producers x1..x4.
      for (int k = 0; k < 4; k++)
         fq.push_back(mk(32'h100 + k, RW'(10 + k), RW'(20 + k), RW'(k + 1), 1, 1, 1));
      apply_head();
      at_neg(); chk("t2_pop0", 64'(fifo_rd_en), 1); adv();
      for (int k = 1; k <= 4; k++) begin
         at_neg();
         chk("t2_valid", 64'(issue_valid), 1);
         if (k < 4) chk("t2_pop", 64'(fifo_rd_en), 1);
         adv();
      end
      at_neg();
      chk("t2_valid_end", 64'(issue_valid), 0);
      chk("t2_busy", 64'(busy_vec), 64'h1E);
      chk("t2_stall", 64'(stall_cycles), 0);
      adv();

      // Table of hazard vectors.
      exp_stall = 0;
      for (int i = 0; i < 8; i++) begin
         fq.delete(); fq.push_back(tv[i].ins); apply_head();
         at_neg();
         chk($sformatf("tbl_rd_en[%0d]", i), 64'(fifo_rd_en), 64'(tv[i].exp_rd_en));
         chk($sformatf("tbl_stall[%0d]", i), 64'(stall_cycles), 64'(exp_stall));
         if (!tv[i].exp_rd_en) exp_stall++;
         adv();
      end
      fq.delete(); apply_head();
      at_neg(); chk("tbl_stall_end", 64'(stall_cycles), 64'(exp_stall)); adv();
      at_neg(); chk("tbl_busy", 64'(busy_vec), 64'h1E); adv();

      // Retire x1..x4.
      for (int r = 1; r <= 4; r++) begin
         wb_valid = 1'b1; wb_rd = RW'(r);
         cycle();
      end
      wb_valid = 1'b0;
      at_neg(); chk("wb_clear_busy", 64'(busy_vec), 0); adv();

      // RAW: producer x5, consumer reads x5 twice.
      fq.push_back(mk(32'h500, 0, 0, 5, 0, 0, 1));
      fq.push_back(mk(32'h501, 5, 5, 6, 1, 1, 1));
      apply_head();
      at_neg(); chk("t3_pop_a", 64'(fifo_rd_en), 1); adv();
      for (int k = 0; k < 3; k++) begin
         at_neg();
         chk("t3_stall_rd_en", 64'(fifo_rd_en), 0);
         chk("t3_stall_cnt", 64'(stall_cycles), 64'(4 + k));
         adv();
      end
      wb_valid = 1'b1; wb_rd = 5'd5;
      at_neg();
      chk("t3_bypass_pop", 64'(fifo_rd_en), 1);
      chk("t3_stall_cnt3", 64'(stall_cycles), 7);
      adv();
      wb_valid = 1'b0;
      at_neg();
      chk("t3_valid_b", 64'(issue_valid), 1);
      chk("t3_stall_frozen", 64'(stall_cycles), 7);
      adv();
      at_neg(); chk("t3_busy", 64'(busy_vec), 64'h40); adv();
      wb_valid = 1'b1; wb_rd = 5'd6;
      cycle();
      wb_valid = 1'b0;

      // Backpressure: five cycles of issue_ready low with the FIFO non-empty.
      fq.push_back(mk(32'hC00, 0, 0, 8, 0, 0, 0));
      fq.push_back(mk(32'hD00, 0, 0, 16, 0, 0, 0));
      apply_head();
      at_neg(); chk("t4_pop_c", 64'(fifo_rd_en), 1); adv();
      issue_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         at_neg();
         chk("t4_valid", 64'(issue_valid), 1);
         chk("t4_instr", 64'(issue_instr), 64'hC00);
         chk("t4_no_pop", 64'(fifo_rd_en), 0);
         adv();
      end
      issue_ready = 1'b1;
      at_neg(); chk("t4_pop_d", 64'(fifo_rd_en), 1); adv();
      at_neg();
      chk("t4_valid_d", 64'(issue_valid), 1);
      chk("t4_stall", 64'(stall_cycles), 7);
      adv();
      at_neg(); chk("t4_empty", 64'(issue_valid), 0); adv();

      // Flush while FULL and ready.
      fq.push_back(mk(32'hE00, 0, 0, 9, 0, 0, 1));
      fq.push_back(mk(32'hF00, 0, 0, 10, 0, 0, 0));
      apply_head();
      at_neg(); chk("t5_pop_e", 64'(fifo_rd_en), 1); adv();
      flush = 1'b1;
      at_neg();
      chk("t5_flush_no_pop", 64'(fifo_rd_en), 0);
      chk("t5_flush_valid", 64'(issue_valid), 1);
      adv();
      flush = 1'b0;
      at_neg();
      chk("t5_dropped", 64'(issue_valid), 0);
      chk("t5_busy", 64'(busy_vec), 0);
      chk("t5_resume_pop", 64'(fifo_rd_en), 1);
      adv();
      at_neg();
      chk("t5_valid_f", 64'(issue_valid), 1);
      chk("t5_instr_f", 64'(issue_instr), 64'hF00);
      adv();

      // x0 producer and consumer; then fire/writeback collision on x7.
      fq.push_back(mk(32'h600, 0, 0, 0, 0, 0, 1));
      fq.push_back(mk(32'h601, 0, 0, 11, 1, 1, 0));
      apply_head();
      at_neg(); chk("t6_pop_g", 64'(fifo_rd_en), 1); adv();
      at_neg(); chk("t6_x0_no_stall", 64'(fifo_rd_en), 1); adv();
      at_neg(); chk("t6_x0_busy", 64'(busy_vec), 0); adv();
      fq.push_back(mk(32'h700, 0, 0, 7, 0, 0, 1));
      apply_head();
      at_neg(); chk("t6_pop_i", 64'(fifo_rd_en), 1); adv();
      wb_valid = 1'b1; wb_rd = 5'd7;
      cycle();
      wb_valid = 1'b0;
      at_neg(); chk("t6_set_wins", 64'(busy_vec), 64'h80); adv();
      wb_valid = 1'b1; wb_rd = 5'd7;
      cycle();
      wb_valid = 1'b0;
      at_neg(); chk("t6_cleared", 64'(busy_vec), 0); adv();

      // Stall counter saturation.
      fq.push_back(mk(32'h800, 0, 0, 14, 0, 0, 1));
      fq.push_back(mk(32'h801, 14, 0, 15, 1, 0, 0));
      apply_head();
      at_neg(); chk("sat_pop_p", 64'(fifo_rd_en), 1); adv();
      for (int k = 0; k < 20; k++) cycle();
      at_neg();
      chk("sat_rd_en", 64'(fifo_rd_en), 0);
      chk("sat_stall", 64'(stall_cycles), 15);
      adv();
      wb_valid = 1'b1; wb_rd = 5'd14;
      at_neg(); chk("sat_release", 64'(fifo_rd_en), 1); adv();
      wb_valid = 1'b0;
      cycle();
      at_neg();
      chk("sat_hold", 64'(stall_cycles), 15);
      chk("sb_drained", 64'(sbq.size()), 0);
      adv();

      // Asynchronous reset with an instruction held and a busy register.
      fq.push_back(mk(32'h900, 0, 0, 12, 0, 0, 1));
      fq.push_back(mk(32'h901, 0, 0, 13, 0, 0, 0));
      apply_head();
      cycle();
      cycle();
      issue_ready = 1'b0;
      at_neg();
      chk("t1_pre_valid", 64'(issue_valid), 1);
      chk("t1_pre_busy", 64'(busy_vec), 64'h1000);
      #2 reset = 1'b1;
      #1;
      chk("t1_valid", 64'(issue_valid), 0);
      chk("t1_busy", 64'(busy_vec), 0);
      chk("t1_stall", 64'(stall_cycles), 0);
      chk("t1_rd_en", 64'(fifo_rd_en), 0);
      sbq.delete(); fq.delete(); apply_head();
      @(posedge clock); #1;
      reset = 1'b0; issue_ready = 1'b1;
      at_neg(); chk("t1_after", 64'(issue_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
